// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the instruction-fetch port, the data port and the shared memory
// port of mem_port_arbiter.
//   slave  : arbiter view (takes requests and memory responses, drives
//            grants, completions and the memory transaction)
//   master : environment view (cores and memory model), directions reversed
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_ready, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output mem_ready, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-outstanding memory port between an instruction-fetch
// requester and a data requester. Data wins ties; grants are combinational
// in IDLE, the winning request is registered onto mem_* and held until
// mem_ready, and the owner's rvalid pulses one cycle after completion.
//
// Ports
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mem_port_arbiter_if.slave (fetch, data and memory ports)
//
// Parameter
//   STARVE_LIMIT : consecutive data grants tolerated while a fetch waits (1-15)
//
// Build option
//   ARB_STARVE_GUARD_EN : when defined, a 4-bit counter of data grants taken
//   while if_req is high forces fetch to win once it reaches STARVE_LIMIT.
//   When undefined, arbitration is strict data priority.
//
// state   | meaning
// IDLE    | no transaction outstanding, grants may be issued
// BUSY_IF | fetch transaction on mem_*, waiting for mem_ready
// BUSY_D  | data transaction on mem_*, waiting for mem_ready
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_D  = 2'd2;

  if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("mem_port_arbiter: STARVE_LIMIT must be 1..15");
  end

  logic [1:0]  state_q, state_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        is_idle;
  logic        fetch_first;
  logic        grant_if;
  logic        grant_d;

  // Gating with reset keeps grants low while the block is held in reset,
  // even if requests are already asserted.
  assign is_idle  = (state_q == IDLE) && reset;
  assign grant_if = is_idle && bus.if_req && (!bus.d_req || fetch_first);
  assign grant_d  = is_idle && bus.d_req && !grant_if;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.if_req || grant_if) begin
      starve_cnt_d = 4'd0;
    end else if (grant_d && starve_cnt_q != 4'hF) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign fetch_first = (starve_cnt_q == LIMIT);
`else
  assign fetch_first = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = BUSY_D;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_we ? bus.d_wdata : 32'd0;
          mem_be_d    = bus.d_we ? bus.d_be : 4'b1111;
        end else if (grant_if) begin
          state_d     = BUSY_IF;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = 32'd0;
          mem_be_d    = 4'b1111;
        end
      end
      BUSY_IF: begin
        if (bus.mem_ready) begin
          state_d     = IDLE;
          if_rvalid_d = 1'b1;
          if_rdata_d  = bus.mem_rdata;
        end
      end
      BUSY_D: begin
        if (bus.mem_ready) begin
          state_d    = IDLE;
          d_rvalid_d = 1'b1;
          // Stores return zero so d_rdata never shows stale bus data.
          d_rdata_d  = mem_we_q ? 32'd0 : bus.mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Derived from state so an asynchronous reset drops it immediately.
  assign bus.mem_req   = (state_q != IDLE);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.if_gnt    = grant_if;
  assign bus.d_gnt     = grant_d;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, giving the maximum consecutive data grants while a fetch waits (range 1-15).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-low
  if_req  in  1  instruction-fetch request, held until if_gnt
  if_addr  in  32  fetch word address
  if_gnt  out  1  fetch accepted (1-cycle pulse)
  if_rvalid  out  1  fetch complete, if_rdata valid (1-cycle pulse)
  if_rdata  out  32  fetched instruction
  d_req  in  1  data request, held until d_gnt
  d_we  in  1  1 = store, 0 = load
  d_addr  in  32  data address
  d_wdata  in  32  store data (replicated lanes)
  d_be  in  4  store byte enables
  d_gnt  out  1  data accepted (1-cycle pulse)
  d_rvalid  out  1  data access complete (1-cycle pulse)
  d_rdata  out  32  load word (unaligned extraction done downstream)
  mem_req  out  1  memory transaction active
  mem_we  out  1  memory write
  mem_addr  out  32  memory address
  mem_wdata  out  32  memory write data
  mem_be  out  4  memory byte enables
  mem_ready  in  1  memory accepts/completes transaction this cycle
  mem_rdata  in  32  memory read data, valid with mem_ready

Function
REQ-004 The FSM SHALL have states IDLE, BUSY_IF and BUSY_D, with exactly one transaction outstanding at a time.
REQ-005 In IDLE, when at least one request is high, if_gnt or d_gnt SHALL assert combinationally for the selected requester.
REQ-006 On that clock edge, the selected address, we, wdata and be SHALL be registered onto the mem_* outputs, and the state SHALL move to BUSY_IF or BUSY_D.
REQ-007 Default selection SHALL be data over fetch when both requests are high.
REQ-008 In IDLE, mem_req SHALL be 0; in BUSY_x, mem_req SHALL be 1 and the mem_* fields SHALL stay stable until mem_ready samples 1.
REQ-009 Fetch transactions SHALL drive mem_we=0 and mem_be=4'b1111.
REQ-010 Loads SHALL drive mem_we=0 and mem_be=4'b1111; stores SHALL pass d_be and d_wdata.
REQ-011 On the edge where mem_ready=1 in BUSY_x, the owner's rdata SHALL load mem_rdata (stores load 0), the owner's rvalid SHALL pulse in the next cycle, and the state SHALL return to IDLE.
REQ-012 In the IDLE cycle where rvalid pulses, a new grant SHALL be allowed, giving a minimum of 2 cycles per transaction.
REQ-013 x_rdata SHALL hold its value until that requester's next completion.
REQ-014 mem_ready while in IDLE SHALL be ignored.
REQ-015 A request dropped before its grant SHALL start no transaction.
REQ-016 Requests arriving while in BUSY_x SHALL wait; gnt SHALL never assert outside IDLE.
REQ-017 if_gnt and d_gnt SHALL never both be 1; if_rvalid and d_rvalid SHALL never both be 1.
REQ-018 mem_ready held low SHALL keep the block in BUSY indefinitely (no timeout).

Reset
REQ-019 While reset=0, the state SHALL be IDLE.
REQ-020 While reset=0, all outputs SHALL be 0: gnts, rvalids, rdatas, mem_req, mem_we, mem_addr, mem_wdata, mem_be.
REQ-021 While reset=0, the starvation counter SHALL be 0.
REQ-022 Reset asserted mid-transaction SHALL drop mem_req immediately and abandon the transaction; no rvalid SHALL follow.
REQ-023 The first grant after reset release SHALL occur no earlier than the first rising edge with reset=1.

Configuration
REQ-024 With ARB_STARVE_GUARD_EN defined, a 4-bit counter SHALL increment on each d_gnt while if_req=1.
REQ-025 With ARB_STARVE_GUARD_EN defined, the counter SHALL clear on if_gnt or whenever if_req=0.
REQ-026 With ARB_STARVE_GUARD_EN defined, when the counter equals STARVE_LIMIT, fetch SHALL win the next arbitration.
REQ-027 Without ARB_STARVE_GUARD_EN, the block SHALL use strict data priority with no counter logic.

Verification
REQ-028 Fetch-only test: if_req, if_addr=0x100, mem_ready=1 the cycle after grant, mem_rdata=0x00500093 -> if_gnt at cycle 0, mem_req cycle 1, if_rvalid with if_rdata=0x00500093 at cycle 2.
REQ-029 Simultaneous test: if_req and d_req (load 0x2000) in the same cycle -> d_gnt first, then if_gnt in the d_rvalid cycle; never both grants.
REQ-030 Store test: d_we=1, d_be=4'b0011, d_wdata=0xBEEFBEEF, mem_ready delayed 3 cycles -> mem_* stable 4 cycles, d_rvalid once, d_rdata=0.
REQ-031 Starvation test with ARB_STARVE_GUARD_EN and STARVE_LIMIT=4: d_req and if_req held high -> 4 d_gnts, then if_gnt, repeating. Without the macro -> if_gnt never.
REQ-032 Reset test: reset=0 during BUSY_D -> mem_req=0 asynchronously, no d_rvalid; after release a fresh request completes normally.
